// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector. Words arrive on a
// valid/ready handshake and leave MSB first on out_bit, one bit per clock.
// A one-word holding buffer lets the next word follow the current one
// without a gap in out_valid.
module seq_bit_serializer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_stall,
  output logic             word_done,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shifter;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [CNT_W-1:0] cnt;

  logic accept;
  logic consume;
  logic last;

  // Handshake and bit-consumption qualifiers derived from registered state
  always_comb begin
    in_ready = ~hold_full;
    busy     = (state == SHIFT) | hold_full;
    accept   = in_valid & ~hold_full;
    consume  = out_valid & ~out_stall;
    last     = consume & (cnt == CNT_W'(WIDTH - 1));
  end

  // Serializer FSM: shifter, holding buffer, bit counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      word_done <= 1'b0;
      hold_full <= 1'b0;
      cnt       <= '0;
    end else begin
      word_done <= last;
      case (state)
        IDLE: begin
          // Hold is always empty here, so an accepted word goes straight
          // into the shifter and its MSB appears on the next cycle.
          if (accept) begin
            shifter   <= in_word;
            out_bit   <= in_word[WIDTH-1];
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (last) begin
            cnt <= '0;
            if (hold_full) begin
              shifter   <= hold;
              out_bit   <= hold[WIDTH-1];
              hold_full <= 1'b0;
            end else if (accept) begin
              // Bypass: word arriving on the last-bit edge skips the hold.
              shifter <= in_word;
              out_bit <= in_word[WIDTH-1];
            end else begin
              out_bit   <= 1'b0;
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            if (consume) begin
              shifter <= {shifter[WIDTH-2:0], 1'b0};
              out_bit <= shifter[WIDTH-2];
              cnt     <= cnt + 1'b1;
            end
            if (accept) begin
              hold      <= in_word;
              hold_full <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed testbench for seq_bit_serializer: single-word, back-to-back with
// ignored third word, stall, bypass on last bit, and mid-word reset.
module tb_seq_bit_serializer;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in_word;
  logic             in_valid;
  logic             in_ready;
  logic             out_bit;
  logic             out_valid;
  logic             out_stall;
  logic             word_done;
  logic             busy;

  int errors = 0;
  int checks = 0;

  seq_bit_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_stall (out_stall),
    .word_done (word_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present a word for exactly one edge (caller guarantees in_ready=1).
  task automatic load(input logic [WIDTH-1:0] w);
    in_word  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  logic [31:0]      stream;
  logic [WIDTH-1:0] w1;
  int               idx;

  initial begin
    reset     = 1'b1;
    in_word   = '0;
    in_valid  = 1'b0;
    out_stall = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_bit",   32'(out_bit),   32'h0);
    check("rst_word_done", 32'(word_done), 32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h1);
    tick();
    check("idle_no_output", 32'(out_valid), 32'h0);

    // Test 1: single word B0B0, no stall
    w1 = 16'hB0B0;
    load(w1);
    for (int j = 0; j < 16; j++) begin
      check($sformatf("t1_bit%0d", j), 32'(out_bit), 32'(w1[15-j]));
      check($sformatf("t1_vld%0d", j), 32'(out_valid), 32'h1);
      check($sformatf("t1_wd%0d", j),  32'(word_done), 32'h0);
      if (j == 8) check("t1_busy", 32'(busy), 32'h1);
      tick();
    end
    check("t1_word_done", 32'(word_done), 32'h1);
    check("t1_end_vld",   32'(out_valid), 32'h0);
    check("t1_end_bit",   32'(out_bit),   32'h0);
    check("t1_end_busy",  32'(busy),      32'h0);
    tick();
    check("t1_wd_pulse", 32'(word_done), 32'h0);

    // Test 2 + 6: B0B0 then FFFF into hold; 1234 offered while hold full
    stream = 32'hB0B0_FFFF;
    load(16'hB0B0);
    for (int j = 0; j < 32; j++) begin
      check($sformatf("t2_bit%0d", j), 32'(out_bit), 32'(stream[31-j]));
      check($sformatf("t2_vld%0d", j), 32'(out_valid), 32'h1);
      check($sformatf("t2_wd%0d", j),  32'(word_done), 32'((j == 16) ? 1 : 0));
      check($sformatf("t2_rdy%0d", j), 32'(in_ready), 32'((j < 2 || j >= 16) ? 1 : 0));
      if (j == 1) begin
        in_word  = 16'hFFFF;
        in_valid = 1'b1;
      end else if (j >= 4 && j <= 6) begin
        in_word  = 16'h1234;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    check("t2_word_done2", 32'(word_done), 32'h1);
    check("t2_end_vld",    32'(out_valid), 32'h0);
    tick();
    check("t6_no_third_word", 32'(out_valid), 32'h0);

    // Test 3: stall for 3 cycles while bit 5 is presented
    load(w1);
    for (int c = 0; c < 19; c++) begin
      idx = (c < 5) ? c : ((c < 9) ? 5 : c - 3);
      check($sformatf("t3_bit_c%0d", c), 32'(out_bit), 32'(w1[15-idx]));
      check($sformatf("t3_vld_c%0d", c), 32'(out_valid), 32'h1);
      out_stall = (c >= 5 && c <= 7);
      tick();
    end
    out_stall = 1'b0;
    check("t3_word_done", 32'(word_done), 32'h1);
    check("t3_end_vld",   32'(out_valid), 32'h0);
    tick();

    // Test 4: bypass of 0001 on the last-bit edge
    load(w1);
    for (int j = 0; j < 15; j++) tick();
    check("t4_last_bit", 32'(out_bit), 32'(w1[0]));
    in_word  = 16'h0001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      check($sformatf("t4_bit%0d", j), 32'(out_bit), 32'((j == 15) ? 1 : 0));
      check($sformatf("t4_vld%0d", j), 32'(out_valid), 32'h1);
      check($sformatf("t4_wd%0d", j),  32'(word_done), 32'((j == 0) ? 1 : 0));
      check($sformatf("t4_busy%0d", j), 32'(busy), 32'h1);
      tick();
    end
    check("t4_word_done", 32'(word_done), 32'h1);
    check("t4_end_vld",   32'(out_valid), 32'h0);
    tick();

    // Test 5: reset while bit 7 is presented
    load(w1);
    for (int j = 0; j < 7; j++) tick();
    check("t5_bit7", 32'(out_bit), 32'(w1[8]));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_vld",   32'(out_valid), 32'h0);
    check("t5_busy",  32'(busy),      32'h0);
    check("t5_ready", 32'(in_ready),  32'h1);
    check("t5_wd",    32'(word_done), 32'h0);
    for (int j = 0; j < 20; j++) begin
      tick();
      check($sformatf("t5_quiet_wd%0d", j),  32'(word_done), 32'h0);
      check($sformatf("t5_quiet_vld%0d", j), 32'(out_valid), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
